// File: rtl/ro_puf_pkg.sv
// Shared types and default sizing for the RO-PUF response engine, RO counter array and key generator.
package ro_puf_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    MEASURE,
    SETTLE,
    COMPARE,
    DONE
  } state_e;

  localparam int N_PAIRS_DEF    = 8;
  localparam int CNT_W_DEF      = 16;
  localparam int WINDOW_DEF     = 250;
  localparam int SETTLE_CYC_DEF = 4;
  localparam int MARGIN_DEF     = 4;

  // Counter width able to hold 0..v-1, never narrower than one bit.
  function automatic int cnt_width(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/ro_puf_resp_engine_if.sv
// Response handshake between the RO-PUF engine (master) and the key generator / helper-data logic (slave).
interface ro_puf_resp_engine_if #(
  parameter int N_PAIRS = ro_puf_pkg::N_PAIRS_DEF
) ();

  localparam int UCNT_W = $clog2(N_PAIRS + 1);

  logic                resp_valid;
  logic                resp_ready;
  logic [N_PAIRS-1:0]  resp;
  logic [N_PAIRS-1:0]  unstable;
  logic [UCNT_W-1:0]   unstable_cnt;

  modport master (
    output resp_valid,
    output resp,
    output unstable,
    output unstable_cnt,
    input  resp_ready
  );

  modport slave (
    input  resp_valid,
    input  resp,
    input  unstable,
    input  unstable_cnt,
    output resp_ready
  );

endinterface

// File: rtl/ro_pair_cmp.sv
// Combinational comparison of one RO counter pair: response bit plus reliability flag.
module ro_pair_cmp #(
  parameter int CNT_W  = 16,
  parameter int MARGIN = 4
) (
  input  logic [CNT_W-1:0] up_i,
  input  logic [CNT_W-1:0] down_i,
  output logic             bit_o,
  output logic             unstable_o
);

  localparam logic [31:0] MARGIN_U = 32'(MARGIN);

  logic [CNT_W-1:0] gap_d;
  logic [31:0]      gap_ext_d;

  // Subtracting the smaller from the larger keeps the gap within CNT_W bits.
  always_comb begin
    bit_o      = (up_i >= down_i);
    gap_d      = bit_o ? (up_i - down_i) : (down_i - up_i);
    gap_ext_d  = 32'(gap_d);
    unstable_o = (gap_ext_d < MARGIN_U);
  end

endmodule

// File: rtl/ro_puf_resp_engine.sv
// Measurement sequencer for N RO counter pairs; compares pairs serially and presents response + unstable mask.
module ro_puf_resp_engine
  import ro_puf_pkg::*;
#(
  parameter int N_PAIRS    = N_PAIRS_DEF,
  parameter int CNT_W      = CNT_W_DEF,
  parameter int WINDOW     = WINDOW_DEF,
  parameter int SETTLE_CYC = SETTLE_CYC_DEF,
  parameter int MARGIN     = MARGIN_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start_i,
  input  logic [N_PAIRS*CNT_W-1:0]   up_cnt_i,
  input  logic [N_PAIRS*CNT_W-1:0]   down_cnt_i,
  output logic                       ro_clr_o,
  output logic                       ro_en_o,
  output logic                       busy_o,
  ro_puf_resp_engine_if.master       resp_if
);

  localparam int WIN_W  = cnt_width(WINDOW);
  localparam int SET_W  = cnt_width(SETTLE_CYC);
  localparam int IDX_W  = cnt_width(N_PAIRS);
  localparam int UCNT_W = $clog2(N_PAIRS + 1);

  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_PAIRS - 1);

  state_e               state_q;
  logic [WIN_W-1:0]     win_cnt_q;
  logic [SET_W-1:0]     set_cnt_q;
  logic [IDX_W-1:0]     idx_q;
  logic                 ro_clr_q;
  logic                 ro_en_q;
  logic                 busy_q;
  logic                 valid_q;
  logic [N_PAIRS-1:0]   resp_q;
  logic [N_PAIRS-1:0]   unstable_q;
  logic [UCNT_W-1:0]    ucnt_q;

  logic [CNT_W-1:0]     up_arr   [N_PAIRS];
  logic [CNT_W-1:0]     down_arr [N_PAIRS];
  logic                 cmp_bit_d;
  logic                 cmp_unst_d;

  for (genvar gi = 0; gi < N_PAIRS; gi++) begin : g_unpack
    assign up_arr[gi]   = up_cnt_i[gi*CNT_W +: CNT_W];
    assign down_arr[gi] = down_cnt_i[gi*CNT_W +: CNT_W];
  end

  // One shared comparator; the pair index walks it across all pairs during COMPARE.
  ro_pair_cmp #(
    .CNT_W  (CNT_W),
    .MARGIN (MARGIN)
  ) u_cmp (
    .up_i       (up_arr[idx_q]),
    .down_i     (down_arr[idx_q]),
    .bit_o      (cmp_bit_d),
    .unstable_o (cmp_unst_d)
  );

  // Outputs are assigned alongside each transition so they are registered decodes of the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      win_cnt_q  <= '0;
      set_cnt_q  <= '0;
      idx_q      <= '0;
      ro_clr_q   <= 1'b0;
      ro_en_q    <= 1'b0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      resp_q     <= '0;
      unstable_q <= '0;
      ucnt_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_q    <= CLEAR;
            ro_clr_q   <= 1'b1;
            busy_q     <= 1'b1;
            resp_q     <= '0;
            unstable_q <= '0;
            ucnt_q     <= '0;
          end
        end
        CLEAR: begin
          state_q   <= MEASURE;
          ro_clr_q  <= 1'b0;
          ro_en_q   <= 1'b1;
          win_cnt_q <= '0;
        end
        MEASURE: begin
          if (win_cnt_q == WIN_LAST) begin
            state_q   <= SETTLE;
            ro_en_q   <= 1'b0;
            set_cnt_q <= '0;
          end else begin
            win_cnt_q <= win_cnt_q + 1'b1;
          end
        end
        SETTLE: begin
          if (set_cnt_q == SET_LAST) begin
            state_q <= COMPARE;
            idx_q   <= '0;
          end else begin
            set_cnt_q <= set_cnt_q + 1'b1;
          end
        end
        COMPARE: begin
          resp_q[idx_q]     <= cmp_bit_d;
          unstable_q[idx_q] <= cmp_unst_d;
          ucnt_q            <= ucnt_q + UCNT_W'(cmp_unst_d);
          if (idx_q == IDX_LAST) begin
            state_q <= DONE;
            valid_q <= 1'b1;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        DONE: begin
          if (resp_if.resp_ready) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q  <= IDLE;
          ro_clr_q <= 1'b0;
          ro_en_q  <= 1'b0;
          busy_q   <= 1'b0;
          valid_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ro_clr_o             = ro_clr_q;
  assign ro_en_o              = ro_en_q;
  assign busy_o               = busy_q;
  assign resp_if.resp_valid   = valid_q;
  assign resp_if.resp         = resp_q;
  assign resp_if.unstable     = unstable_q;
  assign resp_if.unstable_cnt = ucnt_q;

endmodule
